// File: rtl/pio_pkg.sv
// Shared definitions for the pulse-capable Avalon PIO.
//   ADDR_*  : register map offsets (3-bit Avalon address)
//   EDGE_*  : encodings for the EDGE_MODE parameter of the edge detector
package pio_pkg;

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_IN      = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
  localparam logic [2:0] ADDR_PULSE   = 3'd6;
  localparam logic [2:0] ADDR_STATUS  = 3'd7;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;

endpackage

// File: rtl/pio_edge_sync.sv
// Two-flop input synchronizer followed by a third delay flop for edge
// detection.
//   clk, reset : clock and synchronous active-high reset
//   in_i       : asynchronous external inputs
//   sync_o     : synchronized inputs (second flop stage)
//   edge_o     : one-cycle strobe per bit when the selected edge type is seen
module pio_edge_sync
  import pio_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] edge_o
);

  logic [WIDTH-1:0] s1_q, s2_q, s3_q;

  // All three stages clear together, so the cycle right after reset sees
  // s2 == s3 == 0 and can never report an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= in_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_comb begin
    edge_o = s2_q & ~s3_q;
    if (EDGE_MODE == EDGE_FALL) edge_o = ~s2_q & s3_q;
    else if (EDGE_MODE == EDGE_BOTH) edge_o = s2_q ^ s3_q;
  end

  assign sync_o = s2_q;

endmodule

// File: rtl/avalon_pio_pulse.sv
// Avalon-MM parallel I/O with set/clear/auto-clearing pulse outputs and
// edge-capture interrupts.
//   clk, reset        : single clock, synchronous active-high reset
//   address, chipselect, write_n, writedata, readdata : Avalon-MM slave,
//                       zero wait states, combinational read
//   in_port           : asynchronous inputs (synchronized, edge captured)
//   out_port          : registered outputs (data_out)
//   irq               : level interrupt, |(EDGECAP & IRQMASK)
module avalon_pio_pulse
  import pio_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int PULSE_CYCLES = 50000,
  parameter int EDGE_MODE    = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam int CW = $clog2(PULSE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd_hi;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_edge;

  assign wr           = chipselect & ~write_n;
  assign wd           = writedata[WIDTH-1:0];
  assign unused_wd_hi = ^writedata;

  pio_edge_sync #(
    .WIDTH    (WIDTH),
    .EDGE_MODE(EDGE_MODE)
  ) u_edge_sync (
    .clk   (clk),
    .reset (reset),
    .in_i  (in_port),
    .sync_o(in_sync),
    .edge_o(in_edge)
  );

  always_comb begin
    data_d    = data_q;
    irqmask_d = irqmask_q;
    pmask_d   = pmask_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;

    // Pulse timer: expiry is resolved first so that a same-cycle register
    // write can override it on the bits that write touches.
    if (busy_q) begin
      cnt_d = cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        data_d  = data_q & ~pmask_q;
        pmask_d = '0;
        busy_d  = 1'b0;
      end
    end

    if (wr) begin
      case (address)
        ADDR_DATA:    data_d    = wd;
        ADDR_OUTSET:  data_d    = data_d | wd;
        ADDR_OUTCLR:  data_d    = data_d & ~wd;
        ADDR_IRQMASK: irqmask_d = wd;
        ADDR_PULSE: begin
          // A new pulse cancels any same-cycle expiry: start from the
          // pre-expiry state so already-pulsed bits stay high.
          if (wd != '0) begin
            data_d  = data_q | wd;
            pmask_d = pmask_q | wd;
            cnt_d   = CNT_LOAD;
            busy_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // A fresh edge beats a same-cycle write-1-to-clear on the same bit.
    edgecap_d = edgecap_q;
    if (wr && address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~wd;
    edgecap_d = edgecap_d | in_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q    <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
      pmask_q   <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
      pmask_q   <= pmask_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(data_q);
      ADDR_IN:      readdata = 32'(in_sync);
      ADDR_IRQMASK: readdata = 32'(irqmask_q);
      ADDR_EDGECAP: readdata = 32'(edgecap_q);
      ADDR_STATUS:  readdata = 32'(busy_q);
      default:      readdata = '0;
    endcase
  end

  assign out_port = data_q;
  assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_avalon_pio_pulse.sv
module tb_avalon_pio_pulse;

  localparam int W = 8;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [W-1:0] in_port;
  logic [W-1:0] out_port;
  logic        irq;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  avalon_pio_pulse #(.WIDTH(W), .PULSE_CYCLES(P), .EDGE_MODE(0)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time is counted in clock edges; a pulse is an absolute end edge rather
  // than a countdown. Input history is kept per edge; reset flushes it.
  int          n = 8;
  logic [W-1:0] hist [8] = '{default: '0};
  logic [W-1:0] m_data = '0, m_mask = '0, m_irqmask = '0, m_edgecap = '0, m_in = '0;
  bit          m_busy = 1'b0;
  int          m_end = 0;

  always @(posedge clk) begin
    logic [W-1:0] wd, edg, clr;
    bit wr, pw;
    n++;
    if (reset) begin
      m_data = '0; m_mask = '0; m_irqmask = '0; m_edgecap = '0;
      m_busy = 1'b0; m_end = 0;
      hist[n % 8] = '0; hist[(n-1) % 8] = '0; hist[(n-2) % 8] = '0;
    end else begin
      wr  = chipselect && !write_n;
      wd  = writedata[W-1:0];
      edg = hist[(n-2) % 8] & ~hist[(n-3) % 8];
      hist[n % 8] = in_port;
      pw  = wr && address == 3'd6 && wd != '0;
      if (m_busy && n == m_end && !pw) begin
        m_data = m_data & ~m_mask;
        m_mask = '0;
        m_busy = 1'b0;
      end
      clr = '0;
      if (wr) begin
        case (address)
          3'd0: m_data = wd;
          3'd2: m_irqmask = wd;
          3'd3: clr = wd;
          3'd4: m_data = m_data | wd;
          3'd5: m_data = m_data & ~wd;
          3'd6: if (pw) begin
            m_data = m_data | wd;
            m_mask = m_mask | wd;
            m_end  = n + P;
            m_busy = 1'b1;
          end
          default: ;
        endcase
      end
      m_edgecap = (m_edgecap & ~clr) | edg;
    end
    m_in = hist[(n-1) % 8];
  end

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return 32'(m_data);
      3'd1: return 32'(m_in);
      3'd2: return 32'(m_irqmask);
      3'd3: return 32'(m_edgecap);
      3'd7: return 32'(m_busy);
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_port", 32'(out_port), 32'(m_data));
      chk("irq", 32'(irq), 32'(|(m_edgecap & m_irqmask)));
      chk("readdata", readdata, m_read(address));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [2:0] a, input bit w, input logic [31:0] d);
    address = a; chipselect = w; write_n = !w; writedata = d;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic idle(input logic [2:0] a);
    drive(a, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a; #1;
    chk(name, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    idle(3'd0);
    reset = 1'b0;
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    idle(3'd0);

    // Set / clear / load data
    drive(3'd0, 1'b1, 32'hA5); chk("data_a5", 32'(out_port), 32'hA5);
    drive(3'd4, 1'b1, 32'h0A); chk("outset", 32'(out_port), 32'hAF);
    drive(3'd5, 1'b1, 32'h21); chk("outclr", 32'(out_port), 32'h8E);
    drive(3'd1, 1'b1, 32'hFF); chk("ro_write", 32'(out_port), 32'h8E);
    rd(3'd4, 32'h0, "wo_read");
    drive(3'd0, 1'b1, 32'hFFFF_FF00); chk("hi_bits", 32'(out_port), 32'h00);
    rd(3'd0, 32'h0, "data_rd");

    // Single pulse: high for exactly P cycles
    drive(3'd6, 1'b1, 32'h01);
    address = 3'd7;
    chk("pulse_on", 32'(out_port), 32'h01);
    for (int i = 0; i < P - 1; i++) begin
      idle(3'd7);
      chk("pulse_hold", 32'(out_port), 32'h01);
      chk("pulse_busy", readdata, 32'h1);
    end
    idle(3'd7);
    chk("pulse_off", 32'(out_port), 32'h00);
    chk("pulse_idle", readdata, 32'h0);
    drive(3'd6, 1'b1, 32'h00); chk("pulse_zero", readdata, 32'h0);

    // Second pulse two cycles after the first restarts the count
    drive(3'd6, 1'b1, 32'h01);
    idle(3'd7);
    drive(3'd6, 1'b1, 32'h02);
    for (int i = 0; i < P - 1; i++) idle(3'd7);
    chk("retrig_hold", 32'(out_port), 32'h03);
    idle(3'd7);
    chk("retrig_off", 32'(out_port), 32'h00);

    // OUTSET on the expiry cycle keeps the bits it sets
    drive(3'd6, 1'b1, 32'h10);
    for (int i = 0; i < P - 1; i++) idle(3'd7);
    drive(3'd4, 1'b1, 32'h11);
    chk("exp_outset", 32'(out_port), 32'h11);
    // PULSE on the expiry cycle keeps the old mask bits
    drive(3'd6, 1'b1, 32'h20);
    for (int i = 0; i < P - 1; i++) idle(3'd7);
    drive(3'd6, 1'b1, 32'h40);
    chk("exp_pulse", 32'(out_port), 32'h71);
    for (int i = 0; i < P - 1; i++) idle(3'd7);
    chk("exp_pulse_hold", 32'(out_port), 32'h71);
    idle(3'd7);
    chk("exp_pulse_off", 32'(out_port), 32'h11);

    // Edge capture and interrupt
    drive(3'd2, 1'b1, 32'h04);
    in_port = 8'h04;
    idle(3'd1); idle(3'd1);
    chk("in_sync", readdata, 32'h04);
    idle(3'd3);
    chk("edgecap_set", readdata, 32'h04);
    chk("irq_set", 32'(irq), 32'h1);
    drive(3'd3, 1'b1, 32'h04);
    chk("edgecap_clr", readdata, 32'h0);
    chk("irq_clr", 32'(irq), 32'h0);
    in_port = 8'h00;
    repeat (4) idle(3'd3);
    in_port = 8'h04;
    idle(3'd3); idle(3'd3);
    drive(3'd3, 1'b1, 32'h04);
    chk("edge_vs_clr", readdata, 32'h04);
    chk("edge_vs_clr_irq", 32'(irq), 32'h1);

    // Reset in the middle of a pulse with all capture bits set
    in_port = 8'h00;
    repeat (4) idle(3'd3);
    in_port = 8'hFF;
    repeat (4) idle(3'd3);
    chk("edgecap_ff", readdata, 32'hFF);
    drive(3'd6, 1'b1, 32'h01);
    idle(3'd7);
    reset = 1'b1;
    idle(3'd7);
    reset = 1'b0;
    chk("midrst_out", 32'(out_port), 32'h0);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_stat", readdata, 32'h0);
    idle(3'd3);
    chk("no_edge_after_rst", readdata, 32'h0);
    drive(3'd0, 1'b1, 32'h01);
    repeat (P + 2) idle(3'd7);
    chk("no_residual_expiry", 32'(out_port), 32'h01);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
